// File: rtl/fifo_sync_multimode_if.sv
// Handshake bundle for fifo_sync_multimode.
//   master : producer/consumer side (drives clear, wr_en, din, rd_en)
//   slave  : FIFO side (drives dout, valid, flags, error pulses, count)
interface fifo_sync_multimode_if #(
  parameter int DW = 104,
  parameter int AW = 5
);
  logic          clear;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          valid;
  logic          full;
  logic          prog_full;
  logic          empty;
  logic          prog_empty;
  logic          overflow;
  logic          underflow;
  logic [AW:0]   count;

  modport master (
    output clear, wr_en, din, rd_en,
    input  dout, valid, full, prog_full, empty, prog_empty,
           overflow, underflow, count
  );

  modport slave (
    input  clear, wr_en, din, rd_en,
    output dout, valid, full, prog_full, empty, prog_empty,
           overflow, underflow, count
  );
endinterface

// File: rtl/fifo_sync_multimode.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// programmable thresholds, occupancy count, synchronous flush and
// overflow/underflow pulses.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   io    : fifo_sync_multimode_if.slave
//           in  : clear, wr_en, din, rd_en
//           out : dout, valid, full, prog_full, empty, prog_empty,
//                 overflow, underflow, count
module fifo_sync_multimode #(
  parameter int DW         = 104,
  parameter int DEPTH      = 32,
  parameter int PROG_FULL  = DEPTH / 2,
  parameter int PROG_EMPTY = 1,
  parameter int FWFT       = 0,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  fifo_sync_multimode_if.slave io
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] PF_C    = (AW+1)'(PROG_FULL);
  localparam logic [AW:0] PE_C    = (AW+1)'(PROG_EMPTY);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   count_r;
  logic          ovf_r;
  logic          unf_r;
  logic          wr_acc;
  logic          rd_acc;

  // Flags decode the registered count directly, so they reset with it.
  assign io.count      = count_r;
  assign io.full       = (count_r == DEPTH_C);
  assign io.empty      = (count_r == '0);
  assign io.prog_full  = (count_r >= PF_C);
  assign io.prog_empty = (count_r <= PE_C);
  assign io.overflow   = ovf_r;
  assign io.underflow  = unf_r;

  // Acceptance uses pre-edge flags: at full a concurrent read still pops
  // (write rejected), at empty a concurrent write still lands (read rejected).
  assign wr_acc = io.wr_en & ~io.full;
  assign rd_acc = io.rd_en & ~io.empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_r <= '0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else if (io.clear) begin
      wptr    <= '0;
      rptr    <= '0;
      count_r <= '0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      ovf_r <= io.wr_en & io.full;
      unf_r <= io.rd_en & io.empty;
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      if (wr_acc && !rd_acc)      count_r <= count_r + 1'b1;
      else if (rd_acc && !wr_acc) count_r <= count_r - 1'b1;
    end
  end

  // Storage is never reset or flushed; pointers alone define contents.
  always_ff @(posedge clk) begin
    if (wr_acc && !io.clear) mem[wptr[AW-1:0]] <= io.din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head is presented combinationally; forced to zero while empty so
      // dout reads 0 out of reset and after a flush.
      assign io.dout  = io.empty ? '0 : mem[rptr[AW-1:0]];
      assign io.valid = ~io.empty;
    end else begin : g_std
      logic [DW-1:0] dout_r;
      logic          valid_r;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dout_r  <= '0;
          valid_r <= 1'b0;
        end else if (io.clear) begin
          dout_r  <= '0;
          valid_r <= 1'b0;
        end else if (rd_acc) begin
          dout_r  <= mem[rptr[AW-1:0]];
          valid_r <= 1'b1;
        end else begin
          valid_r <= 1'b0;
        end
      end

      assign io.dout  = dout_r;
      assign io.valid = valid_r;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_multimode.sv
module tb_fifo_sync_multimode;
  localparam int DW    = 104;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_sync_multimode_if #(.DW(DW), .AW(AW)) s_if ();
  fifo_sync_multimode_if #(.DW(DW), .AW(AW)) f_if ();

  fifo_sync_multimode #(.DW(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .io(s_if)
  );
  fifo_sync_multimode #(.DW(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .io(f_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Models: stored contents of each FIFO, and the standard-mode read
  // scoreboard (expected dout words, pushed when an accepted read is driven).
  logic [DW-1:0] mq [$];
  logic [DW-1:0] fq [$];
  logic [DW-1:0] exp_q [$];
  bit s_rv;          // a read was accepted at the last std edge
  bit s_ovf, s_unf;  // expected error pulses after the last std edge
  bit f_ovf, f_unf;

  function automatic logic [DW-1:0] mk(input int i);
    return {8'(i ^ 8'h5A), 64'hDEAD_BEEF_0000_0000 | 64'(i), 32'(i)};
  endfunction

  task automatic s_step(input bit w, input logic [DW-1:0] d, input bit r, input bit c = 1'b0);
    bit w_acc, r_acc;
    s_if.wr_en = w; s_if.din = d; s_if.rd_en = r; s_if.clear = c;
    w_acc = w && (mq.size() < DEPTH) && !c;
    r_acc = r && (mq.size() > 0) && !c;
    s_ovf = w && (mq.size() == DEPTH) && !c;
    s_unf = r && (mq.size() == 0) && !c;
    if (r_acc) exp_q.push_back(mq[0]);
    @(posedge clk); #1;
    if (c) mq.delete();
    else begin
      if (r_acc) void'(mq.pop_front());
      if (w_acc) mq.push_back(d);
    end
    s_rv = r_acc;
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.clear = 1'b0;
  endtask

  task automatic f_step(input bit w, input logic [DW-1:0] d, input bit r);
    bit w_acc, r_acc;
    f_if.wr_en = w; f_if.din = d; f_if.rd_en = r; f_if.clear = 1'b0;
    w_acc = w && (fq.size() < DEPTH);
    r_acc = r && (fq.size() > 0);
    f_ovf = w && (fq.size() == DEPTH);
    f_unf = r && (fq.size() == 0);
    @(posedge clk); #1;
    if (r_acc) void'(fq.pop_front());
    if (w_acc) fq.push_back(d);
    f_if.wr_en = 1'b0; f_if.rd_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    s_if.clear = 0; s_if.wr_en = 0; s_if.rd_en = 0; s_if.din = '0;
    f_if.clear = 0; f_if.wr_en = 0; f_if.rd_en = 0; f_if.din = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({s_if.full, s_if.empty, s_if.prog_full, s_if.prog_empty, s_if.overflow, s_if.underflow, s_if.valid} !== 7'b0101000) begin
      n_err++; $display("FAIL reset_std_flags: got %b want 0101000", {s_if.full, s_if.empty, s_if.prog_full, s_if.prog_empty, s_if.overflow, s_if.underflow, s_if.valid}); end
    n_cmp++; if (s_if.count !== 6'd0 || s_if.dout !== '0) begin
      n_err++; $display("FAIL reset_std_count_dout: got count=%0d dout=%h want 0/0", s_if.count, s_if.dout); end
    n_cmp++; if ({f_if.full, f_if.empty, f_if.valid, f_if.count} !== {3'b010, 6'd0}) begin
      n_err++; $display("FAIL reset_fwft: got full=%b empty=%b valid=%b count=%0d want 0 1 0 0", f_if.full, f_if.empty, f_if.valid, f_if.count); end
    #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < DEPTH; i++) begin
      s_step(1, mk(i), 0);
      n_cmp++; if (s_if.count !== 6'(i + 1) || s_if.empty !== 1'b0) begin
        n_err++; $display("FAIL fill_count[%0d]: got count=%0d empty=%b want %0d 0", i, s_if.count, s_if.empty, i + 1); end
      n_cmp++; if (s_if.prog_full !== (i + 1 >= 16) || s_if.full !== (i == DEPTH - 1)) begin
        n_err++; $display("FAIL fill_flags[%0d]: got prog_full=%b full=%b want %b %b", i, s_if.prog_full, s_if.full, i + 1 >= 16, i == DEPTH - 1); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      s_step(0, '0, 1);
      n_cmp++; if (s_if.valid !== 1'b1 || s_if.dout !== exp_q.pop_front() || s_if.dout !== mk(i)) begin
        n_err++; $display("FAIL drain_data[%0d]: got valid=%b dout=%h want 1 %h", i, s_if.valid, s_if.dout, mk(i)); end
      n_cmp++; if (s_if.count !== 6'(DEPTH - 1 - i) || s_if.full !== 1'b0) begin
        n_err++; $display("FAIL drain_count[%0d]: got count=%0d full=%b want %0d 0", i, s_if.count, s_if.full, DEPTH - 1 - i); end
    end
    n_cmp++; if (s_if.empty !== 1'b1 || s_if.prog_empty !== 1'b1) begin
      n_err++; $display("FAIL drain_empty: got empty=%b prog_empty=%b want 1 1", s_if.empty, s_if.prog_empty); end
  endtask

  task automatic test_errors;
    logic [DW-1:0] prev;
    for (int i = 0; i < DEPTH; i++) s_step(1, mk(100 + i), 0);
    s_step(1, mk(999), 0);
    n_cmp++; if (s_if.overflow !== 1'b1 || s_if.count !== 6'd32 || s_ovf !== 1'b1) begin
      n_err++; $display("FAIL overflow_pulse: got ovf=%b count=%0d want 1 32", s_if.overflow, s_if.count); end
    s_step(0, '0, 0);
    n_cmp++; if (s_if.overflow !== 1'b0) begin
      n_err++; $display("FAIL overflow_one_cycle: got %b want 0", s_if.overflow); end
    s_step(1, mk(998), 1);
    n_cmp++; if (s_if.count !== 6'd31 || s_if.overflow !== 1'b1 || s_if.full !== 1'b0) begin
      n_err++; $display("FAIL full_rw: got count=%0d ovf=%b full=%b want 31 1 0", s_if.count, s_if.overflow, s_if.full); end
    n_cmp++; if (s_if.valid !== 1'b1 || s_if.dout !== exp_q.pop_front()) begin
      n_err++; $display("FAIL full_rw_data: got valid=%b dout=%h want 1 %h", s_if.valid, s_if.dout, mk(100)); end
    while (mq.size() > 0) begin
      s_step(0, '0, 1);
      n_cmp++; if (s_if.dout !== exp_q.pop_front()) begin
        n_err++; $display("FAIL err_drain: got dout=%h", s_if.dout); end
    end
    n_cmp++; if (s_if.dout !== mk(131)) begin
      n_err++; $display("FAIL err_drain_last: got %h want %h", s_if.dout, mk(131)); end
    prev = s_if.dout;
    s_step(0, '0, 1);
    n_cmp++; if (s_if.underflow !== 1'b1 || s_unf !== 1'b1 || s_if.valid !== 1'b0 || s_if.dout !== prev) begin
      n_err++; $display("FAIL underflow_pulse: got unf=%b valid=%b dout=%h want 1 0 %h", s_if.underflow, s_if.valid, s_if.dout, prev); end
    s_step(1, mk(5), 1);
    n_cmp++; if (s_if.underflow !== 1'b1 || s_if.count !== 6'd1 || s_if.valid !== 1'b0) begin
      n_err++; $display("FAIL empty_rw: got unf=%b count=%0d valid=%b want 1 1 0", s_if.underflow, s_if.count, s_if.valid); end
    s_step(0, '0, 1);
    n_cmp++; if (s_if.underflow !== 1'b0 || s_if.dout !== exp_q.pop_front()) begin
      n_err++; $display("FAIL empty_rw_data: got unf=%b dout=%h want 0 %h", s_if.underflow, s_if.dout, mk(5)); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 20; i++) s_step(1, mk(200 + i), 0);
    for (int k = 0; k < 100; k++) begin
      s_step(1, mk(300 + k), 1);
      n_cmp++; if (s_if.count !== 6'd20 || s_if.valid !== 1'b1 || s_if.dout !== exp_q.pop_front()) begin
        n_err++; $display("FAIL wrap[%0d]: got count=%0d valid=%b dout=%h", k, s_if.count, s_if.valid, s_if.dout); end
    end
    for (int i = 0; i < 20; i++) begin
      s_step(0, '0, 1);
      n_cmp++; if (s_if.dout !== exp_q.pop_front() || s_if.dout !== mk(380 + i)) begin
        n_err++; $display("FAIL wrap_drain[%0d]: got %h want %h", i, s_if.dout, mk(380 + i)); end
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 10; i++) s_step(1, mk(500 + i), 0);
    s_step(1, mk(777), 0, 1);
    n_cmp++; if (s_if.count !== 6'd0 || s_if.empty !== 1'b1 || s_if.prog_empty !== 1'b1 || s_if.overflow !== 1'b0) begin
      n_err++; $display("FAIL flush: got count=%0d empty=%b prog_empty=%b ovf=%b want 0 1 1 0", s_if.count, s_if.empty, s_if.prog_empty, s_if.overflow); end
    n_cmp++; if (s_if.valid !== 1'b0 || s_if.dout !== '0) begin
      n_err++; $display("FAIL flush_dout: got valid=%b dout=%h want 0 0", s_if.valid, s_if.dout); end
    s_step(0, '0, 1);
    n_cmp++; if (s_if.underflow !== 1'b1 || s_if.valid !== 1'b0) begin
      n_err++; $display("FAIL flush_discard: got unf=%b valid=%b want 1 0", s_if.underflow, s_if.valid); end
    s_step(1, mk(501), 0);
    s_step(0, '0, 1);
    n_cmp++; if (s_if.dout !== exp_q.pop_front() || s_if.dout !== mk(501)) begin
      n_err++; $display("FAIL flush_after: got %h want %h", s_if.dout, mk(501)); end
  endtask

  task automatic test_fwft;
    f_step(1, DW'('hA5), 0);
    n_cmp++; if (f_if.valid !== 1'b1 || f_if.dout !== fq[0] || f_if.dout !== DW'('hA5)) begin
      n_err++; $display("FAIL fwft_head: got valid=%b dout=%h want 1 a5", f_if.valid, f_if.dout); end
    f_step(0, '0, 1);
    n_cmp++; if (f_if.valid !== 1'b0 || f_if.empty !== 1'b1) begin
      n_err++; $display("FAIL fwft_pop: got valid=%b empty=%b want 0 1", f_if.valid, f_if.empty); end
    for (int i = 0; i < 3; i++) f_step(1, mk(600 + i), 0);
    n_cmp++; if (f_if.count !== 6'd3 || f_if.dout !== mk(600)) begin
      n_err++; $display("FAIL fwft_fill: got count=%0d dout=%h want 3 %h", f_if.count, f_if.dout, mk(600)); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (f_if.valid !== 1'b1 || f_if.dout !== fq[0]) begin
        n_err++; $display("FAIL fwft_seq[%0d]: got valid=%b dout=%h want 1 %h", i, f_if.valid, f_if.dout, mk(600 + i)); end
      f_step(0, '0, 1);
    end
    f_step(0, '0, 1);
    n_cmp++; if (f_if.underflow !== f_unf || f_if.underflow !== 1'b1 || f_if.valid !== 1'b0) begin
      n_err++; $display("FAIL fwft_underflow: got unf=%b valid=%b want 1 0", f_if.underflow, f_if.valid); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) s_step(1, mk(650 + i), 0);
    f_step(1, mk(660), 0);
    f_step(1, mk(661), 0);
    s_if.wr_en = 1; s_if.rd_en = 1; s_if.din = mk(670);
    f_if.wr_en = 1; f_if.din = mk(671);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({s_if.full, s_if.empty, s_if.prog_full, s_if.prog_empty, s_if.overflow, s_if.underflow, s_if.valid} !== 7'b0101000 || s_if.count !== 6'd0 || s_if.dout !== '0) begin
      n_err++; $display("FAIL async_reset_std: got flags=%b count=%0d dout=%h", {s_if.full, s_if.empty, s_if.prog_full, s_if.prog_empty, s_if.overflow, s_if.underflow, s_if.valid}, s_if.count, s_if.dout); end
    n_cmp++; if (f_if.count !== 6'd0 || f_if.valid !== 1'b0 || f_if.empty !== 1'b1 || f_if.dout !== '0) begin
      n_err++; $display("FAIL async_reset_fwft: got count=%0d valid=%b empty=%b dout=%h", f_if.count, f_if.valid, f_if.empty, f_if.dout); end
    @(posedge clk); #1;
    s_if.wr_en = 0; s_if.rd_en = 0; f_if.wr_en = 0;
    #2 reset = 1'b0;
    mq.delete(); fq.delete(); exp_q.delete();
    @(posedge clk); #1;
    n_cmp++; if (s_if.empty !== 1'b1 || s_if.count !== 6'd0 || f_if.empty !== 1'b1 || f_if.count !== 6'd0) begin
      n_err++; $display("FAIL post_reset_empty: got std empty=%b count=%0d fwft empty=%b count=%0d", s_if.empty, s_if.count, f_if.empty, f_if.count); end
    s_step(1, mk(700), 0);
    s_step(0, '0, 1);
    n_cmp++; if (s_if.valid !== 1'b1 || s_if.dout !== exp_q.pop_front()) begin
      n_err++; $display("FAIL post_reset_rw: got valid=%b dout=%h want 1 %h", s_if.valid, s_if.dout, mk(700)); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_errors();
    test_wrap();
    test_flush();
    test_fwft();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
